// File: rtl/hazard_unit_if.sv
// Hazard controller bundle: pipeline status in, latch enables/flushes out.
// The pipeline owns the master side; the hazard unit owns the slave side.
interface hazard_unit_if #(
    parameter int CNT_W = 32
);
    logic             ihit;
    logic             dhit;
    logic             exmem_dren;
    logic             exmem_dwen;
    logic             exmem_brtaken;
    logic             exmem_halt;
    logic             idex_memread;
    logic [4:0]       idex_wsel;
    logic [4:0]       ifid_rs;
    logic [4:0]       ifid_rt;
    logic             ifid_usert;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             exmem_flush;
    logic             memwb_en;
    logic             halted;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output ihit, dhit, exmem_dren, exmem_dwen,
        output exmem_brtaken, exmem_halt, idex_memread,
        output idex_wsel, ifid_rs, ifid_rt, ifid_usert,
        input  pc_en, ifid_en, ifid_flush, idex_en,
        input  idex_flush, exmem_en, exmem_flush, memwb_en,
        input  halted, stall_count
    );

    modport slave (
        input  ihit, dhit, exmem_dren, exmem_dwen,
        input  exmem_brtaken, exmem_halt, idex_memread,
        input  idex_wsel, ifid_rs, ifid_rt, ifid_usert,
        output pc_en, ifid_en, ifid_flush, idex_en,
        output idex_flush, exmem_en, exmem_flush, memwb_en,
        output halted, stall_count
    );
endinterface

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline.
// Handles halt, dmem wait, taken branch, load-use and imem miss.
module hazard_unit #(
    parameter int CNT_W = 32
) (
    input  logic          CLK,
    input  logic          RST,
    hazard_unit_if.slave  hif
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic pc_en, ifid_en, ifid_flush, idex_en;
    logic idex_flush, exmem_en, exmem_flush, memwb_en;
    logic dmiss, load_use;

    assign dmiss = (hif.exmem_dren | hif.exmem_dwen) & ~hif.dhit;

    assign load_use = hif.idex_memread
                    & (hif.idex_wsel != 5'd0)
                    & ((hif.idex_wsel == hif.ifid_rs)
                     | (hif.ifid_usert
                      & (hif.idex_wsel == hif.ifid_rt)));

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        exmem_flush = 1'b0;
        memwb_en    = 1'b0;
        state_d     = state_q;
        if (!RST && state_q != HALTED) begin
            state_d = RUN;
            if (hif.exmem_halt) begin
                memwb_en = 1'b1;
                state_d  = HALTED;
            end else if (dmiss) begin
                state_d = DWAIT;
            end else if (hif.exmem_brtaken) begin
                pc_en       = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                memwb_en    = 1'b1;
            end else if (load_use) begin
                // One bubble suffices: the load leaves EX next cycle
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else if (!hif.ihit) begin
                ifid_flush = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!pc_en && state_q != HALTED && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hif.pc_en       = pc_en;
    assign hif.ifid_en     = ifid_en;
    assign hif.ifid_flush  = ifid_flush;
    assign hif.idex_en     = idex_en;
    assign hif.idex_flush  = idex_flush;
    assign hif.exmem_en    = exmem_en;
    assign hif.exmem_flush = exmem_flush;
    assign hif.memwb_en    = memwb_en;
    assign hif.halted      = (state_q == HALTED) & ~RST;
    assign hif.stall_count = cnt_q;
endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus random
// stimulus against a cycle-level behavioural model.
module tb_hazard_unit;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    localparam logic [7:0] ALL_EN = 8'b1101_0101;
    localparam logic [7:0] FREEZE = 8'b0000_0000;
    localparam logic [7:0] HALT1  = 8'b0000_0001;
    localparam logic [7:0] BRANCH = 8'b1010_1011;
    localparam logic [7:0] LDUSE  = 8'b0000_1101;
    localparam logic [7:0] IMISS  = 8'b0011_0101;

    logic CLK;
    logic RST;
    int   n_vec;
    int   n_err;
    int   m_cnt;
    bit   m_halted;

    hazard_unit_if #(.CNT_W(CNT_W)) hif ();

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .hif (hif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en}
    function automatic logic [7:0] ctl();
        return {hif.pc_en, hif.ifid_en, hif.ifid_flush, hif.idex_en,
                hif.idex_flush, hif.exmem_en, hif.exmem_flush, hif.memwb_en};
    endfunction

    function automatic logic [7:0] exp_ctl();
        bit lu;
        lu = hif.idex_memread && hif.idex_wsel != 0 &&
             (hif.idex_wsel == hif.ifid_rs ||
              (hif.ifid_usert && hif.idex_wsel == hif.ifid_rt));
        if (RST || m_halted) return FREEZE;
        if (hif.exmem_halt) return HALT1;
        if ((hif.exmem_dren || hif.exmem_dwen) && !hif.dhit) return FREEZE;
        if (hif.exmem_brtaken) return BRANCH;
        if (lu) return LDUSE;
        if (!hif.ihit) return IMISS;
        return ALL_EN;
    endfunction

    task automatic idle();
        hif.ihit = 1; hif.dhit = 0;
        hif.exmem_dren = 0; hif.exmem_dwen = 0;
        hif.exmem_brtaken = 0; hif.exmem_halt = 0;
        hif.idex_memread = 0; hif.idex_wsel = 0;
        hif.ifid_rs = 0; hif.ifid_rt = 0; hif.ifid_usert = 0;
    endtask

    task automatic tick();
        logic [7:0] e;
        e = exp_ctl();
        @(posedge CLK);
        if (RST) begin
            m_halted = 0;
            m_cnt    = 0;
        end else if (!m_halted) begin
            if (!e[7] && m_cnt < CMAX) m_cnt++;
            if (hif.exmem_halt) m_halted = 1;
        end
        #1;
    endtask

    task automatic rst_pulse();
        idle();
        RST = 1;
        tick();
        RST = 0;
    endtask

    task automatic test_reset();
        idle();
        RST = 1;
        hif.exmem_brtaken = 1;
        @(negedge CLK);
        n_vec++;
        if (ctl() !== FREEZE) begin
            n_err++;
            $display("FAIL rst_ctl got %b exp %b", ctl(), FREEZE);
        end
        tick();
        RST = 0;
        idle();
        @(negedge CLK);
        n_vec++;
        if (hif.stall_count !== '0 || hif.halted !== 1'b0) begin
            n_err++;
            $display("FAIL rst_state cnt %0d halted %b exp 0 0",
                     hif.stall_count, hif.halted);
        end
        n_vec++;
        if (ctl() !== ALL_EN) begin
            n_err++;
            $display("FAIL rst_run got %b exp %b", ctl(), ALL_EN);
        end
        tick();
    endtask

    task automatic test_load_use();
        rst_pulse();
        hif.idex_memread = 1; hif.idex_wsel = 5; hif.ifid_rs = 5;
        @(negedge CLK);
        n_vec++;
        if (ctl() !== LDUSE) begin
            n_err++;
            $display("FAIL lu_ctl got %b exp %b", ctl(), LDUSE);
        end
        tick();
        idle();
        @(negedge CLK);
        n_vec++;
        if (ctl() !== ALL_EN || hif.stall_count !== 4'd1) begin
            n_err++;
            $display("FAIL lu_after got %b cnt %0d exp %b cnt 1",
                     ctl(), hif.stall_count, ALL_EN);
        end
        tick();
        // rt match only counts when the ID instruction reads rt
        hif.idex_memread = 1; hif.idex_wsel = 7; hif.ifid_rt = 7;
        @(negedge CLK);
        n_vec++;
        if (ctl() !== ALL_EN) begin
            n_err++;
            $display("FAIL lu_rt_unused got %b exp %b", ctl(), ALL_EN);
        end
        hif.ifid_usert = 1;
        @(negedge CLK);
        n_vec++;
        if (ctl() !== LDUSE) begin
            n_err++;
            $display("FAIL lu_rt got %b exp %b", ctl(), LDUSE);
        end
        tick();
    endtask

    task automatic test_dest_zero();
        rst_pulse();
        hif.idex_memread = 1; hif.idex_wsel = 0;
        hif.ifid_rs = 0; hif.ifid_rt = 0; hif.ifid_usert = 1;
        @(negedge CLK);
        n_vec++;
        if (ctl() !== ALL_EN) begin
            n_err++;
            $display("FAIL r0_ctl got %b exp %b", ctl(), ALL_EN);
        end
        tick();
        @(negedge CLK);
        n_vec++;
        if (hif.stall_count !== 4'd0) begin
            n_err++;
            $display("FAIL r0_cnt got %0d exp 0", hif.stall_count);
        end
        tick();
    endtask

    task automatic test_dmiss();
        rst_pulse();
        hif.exmem_dren = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_vec++;
            if (ctl() !== FREEZE) begin
                n_err++;
                $display("FAIL dmiss_freeze%0d got %b exp %b", i, ctl(), FREEZE);
            end
            tick();
        end
        hif.dhit = 1;
        @(negedge CLK);
        n_vec++;
        if (ctl() !== ALL_EN || hif.stall_count !== 4'd3) begin
            n_err++;
            $display("FAIL dmiss_exit got %b cnt %0d exp %b cnt 3",
                     ctl(), hif.stall_count, ALL_EN);
        end
        tick();
        // Branch under a pending miss: freeze first, flush on the dhit cycle
        hif.exmem_dren = 0; hif.exmem_dwen = 1;
        hif.dhit = 0; hif.exmem_brtaken = 1;
        @(negedge CLK);
        n_vec++;
        if (ctl() !== FREEZE) begin
            n_err++;
            $display("FAIL dmiss_br_freeze got %b exp %b", ctl(), FREEZE);
        end
        tick();
        hif.dhit = 1;
        @(negedge CLK);
        n_vec++;
        if (ctl() !== BRANCH) begin
            n_err++;
            $display("FAIL dmiss_br_flush got %b exp %b", ctl(), BRANCH);
        end
        tick();
    endtask

    task automatic test_branch_load_use();
        rst_pulse();
        hif.idex_memread = 1; hif.idex_wsel = 5; hif.ifid_rs = 5;
        hif.exmem_brtaken = 1; hif.ihit = 0;
        @(negedge CLK);
        n_vec++;
        if (ctl() !== BRANCH) begin
            n_err++;
            $display("FAIL br_lu_ctl got %b exp %b", ctl(), BRANCH);
        end
        tick();
        idle();
        @(negedge CLK);
        n_vec++;
        if (hif.stall_count !== 4'd0) begin
            n_err++;
            $display("FAIL br_lu_cnt got %0d exp 0", hif.stall_count);
        end
        tick();
    endtask

    task automatic test_halt();
        rst_pulse();
        hif.exmem_halt = 1;
        @(negedge CLK);
        n_vec++;
        if (ctl() !== HALT1 || hif.halted !== 1'b0) begin
            n_err++;
            $display("FAIL halt_cycle got %b h %b exp %b h 0",
                     ctl(), hif.halted, HALT1);
        end
        tick();
        for (int i = 0; i < 6; i++) begin
            hif.ihit = 1'($urandom); hif.dhit = 1'($urandom);
            hif.exmem_dren = 1'($urandom); hif.exmem_halt = 1'($urandom);
            hif.exmem_brtaken = 1'($urandom);
            @(negedge CLK);
            n_vec++;
            if (ctl() !== FREEZE || hif.halted !== 1'b1 ||
                hif.stall_count !== 4'd1) begin
                n_err++;
                $display("FAIL halt_hold%0d got %b h %b cnt %0d exp %b h 1 cnt 1",
                         i, ctl(), hif.halted, hif.stall_count, FREEZE);
            end
            tick();
        end
        rst_pulse();
        @(negedge CLK);
        n_vec++;
        if (ctl() !== ALL_EN || hif.halted !== 1'b0 ||
            hif.stall_count !== 4'd0) begin
            n_err++;
            $display("FAIL halt_rst got %b h %b cnt %0d exp %b h 0 cnt 0",
                     ctl(), hif.halted, hif.stall_count, ALL_EN);
        end
        tick();
    endtask

    task automatic test_saturation();
        rst_pulse();
        hif.ihit = 0;
        for (int i = 0; i < 20; i++) tick();
        @(negedge CLK);
        n_vec++;
        if (hif.stall_count !== 4'd15) begin
            n_err++;
            $display("FAIL sat_cnt got %0d exp 15", hif.stall_count);
        end
        tick();
        // Reset mid-stall clears the counter and resumes normal flow
        rst_pulse();
        @(negedge CLK);
        n_vec++;
        if (hif.stall_count !== 4'd0 || ctl() !== ALL_EN) begin
            n_err++;
            $display("FAIL sat_rst got %b cnt %0d exp %b cnt 0",
                     ctl(), hif.stall_count, ALL_EN);
        end
        tick();
    endtask

    task automatic test_random();
        logic [7:0] e;
        rst_pulse();
        for (int i = 0; i < 600; i++) begin
            RST = ($urandom_range(99) < (m_halted ? 20 : 2));
            hif.ihit          = ($urandom_range(99) < 80);
            hif.dhit          = ($urandom_range(99) < 50);
            hif.exmem_dren    = ($urandom_range(99) < 20);
            hif.exmem_dwen    = ($urandom_range(99) < 10);
            hif.exmem_brtaken = ($urandom_range(99) < 15);
            hif.exmem_halt    = ($urandom_range(99) < 2);
            hif.idex_memread  = ($urandom_range(99) < 40);
            hif.idex_wsel     = 5'($urandom_range(3));
            hif.ifid_rs       = 5'($urandom_range(3));
            hif.ifid_rt       = 5'($urandom_range(3));
            hif.ifid_usert    = 1'($urandom);
            @(negedge CLK);
            e = exp_ctl();
            n_vec++;
            if (ctl() !== e || hif.halted !== (m_halted && !RST) ||
                hif.stall_count !== CNT_W'(m_cnt)) begin
                n_err++;
                $display("FAIL rand%0d got %b h %b cnt %0d exp %b h %b cnt %0d",
                         i, ctl(), hif.halted, hif.stall_count,
                         e, m_halted && !RST, m_cnt);
            end
            tick();
        end
        RST = 0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_cnt = 0;
        m_halted = 0;
        RST = 1;
        idle();
        test_reset();
        test_load_use();
        test_dest_zero();
        test_dmiss();
        test_branch_load_use();
        test_halt();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
